// File: rtl/arilla_timer_responder_if.sv
// arilla_bus_if: shared word-addressed bus between the core's initiator and
// its responders.
//
// Both sides have their own data driver and output enable. The shared `data`
// net is resolved from them and floats (high-Z) when neither side drives it.
//   address     : word address, driven by the initiator
//   byte_enable : per-byte lane enables for writes
//   read, write : transfer request strobes
//   init_data / init_oe : initiator data driver and its enable
//   resp_data / resp_oe : responder data driver and its enable
//   data        : resolved bus data, seen by both sides
interface arilla_bus_if;
  logic [31:0] address;
  logic [3:0]  byte_enable;
  logic        read;
  logic        write;
  logic [31:0] init_data;
  logic        init_oe;
  logic [31:0] resp_data;
  logic        resp_oe;
  wire  [31:0] data;
  wire  [31:0] data_val;
  wire         data_oe;

  // The initiator owns the bus whenever it drives. Otherwise the responder may drive.
  assign data_val = init_oe ? init_data : resp_data;
  assign data_oe  = init_oe | resp_oe;
  assign data     = data_oe ? data_val : {32{1'bz}};

  modport responder (
    input  address, byte_enable, read, write, data,
    output resp_data, resp_oe
  );

  modport initiator (
    output address, byte_enable, read, write, init_data, init_oe,
    input  data, resp_oe
  );
endinterface

// File: rtl/arilla_timer_responder.sv
// arilla_timer_responder: memory-mapped RISC-V machine timer on arilla_bus.
//
// The timer occupies an 8-word window at BaseAddress (a word address whose
// low 3 bits are ignored):
//   0 mtime[31:0]   1 mtime[63:32]   2 mtimecmp[31:0]   3 mtimecmp[63:32]
//   4 control: bit0 enable, bits[8 +: PrescaleWidth] prescale
//   5..7 reserved: these read 0 and ignore writes
// Writes merge byte lanes and complete in their own cycle. A read is
// accepted in one cycle and answered in the next.
//
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   bus_interface : arilla_bus_if responder modport
//   timer_irq     : registered machine timer interrupt (mtime >= mtimecmp)
module arilla_timer_responder #(
  parameter logic [31:0] BaseAddress   = 32'h0000_0200,
  parameter int unsigned PrescaleWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arilla_bus_if.responder       bus_interface,
  output logic                  timer_irq
);

  localparam int unsigned AddrW  = $bits(bus_interface.address);
  localparam int unsigned DataW  = $bits(bus_interface.data);
  localparam int unsigned LanesN = DataW / 8;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [DataW-1:0] merge_bytes(
    input logic [DataW-1:0]  old_word,
    input logic [DataW-1:0]  new_word,
    input logic [LanesN-1:0] lane_en
  );
    logic [DataW-1:0] merged;
    merged = old_word;
    for (int j = 0; j < int'(LanesN); j++) begin
      if (lane_en[j]) merged[8*j +: 8] = new_word[8*j +: 8];
      else            merged[8*j +: 8] = old_word[8*j +: 8];
    end
    return merged;
  endfunction

  logic [63:0]              r_mtime;
  logic [63:0]              r_mtimecmp;
  logic                     r_enable;
  logic [PrescaleWidth-1:0] r_prescale;
  logic [PrescaleWidth-1:0] r_divider;
  logic                     r_irq;
  logic                     r_resp_valid;
  logic [DataW-1:0]         r_resp_data;

  logic                     w_hit;
  logic [2:0]               w_offset;
  logic                     w_wr;
  logic                     w_rd;
  logic                     w_tick;
  logic [DataW-1:0]         w_wdata;
  logic [LanesN-1:0]        w_be;
  logic [DataW-1:0]         w_ctrl_word;
  logic [DataW-1:0]         w_ctrl_merge;
  logic [DataW-1:0]         w_rdata;
  logic [63:0]              w_mtime_nxt;
  logic [63:0]              w_mtimecmp_nxt;
  logic                     w_enable_nxt;
  logic [PrescaleWidth-1:0] w_prescale_nxt;
  logic [PrescaleWidth-1:0] w_divider_nxt;

  assign w_hit    = (bus_interface.address[AddrW-1:3] == BaseAddress[AddrW-1:3]);
  assign w_offset = bus_interface.address[2:0];
  assign w_wr     = bus_interface.write & w_hit;
  // A simultaneous read and write is treated as a write only, so no response is produced.
  assign w_rd     = bus_interface.read & w_hit & ~bus_interface.write;
  assign w_wdata  = bus_interface.data;
  assign w_be     = bus_interface.byte_enable;
  assign w_tick   = r_enable & (r_divider == r_prescale);

  // Build the control register image and select the read word.
  always_comb begin
    w_ctrl_word                    = '0;
    w_ctrl_word[0]                 = r_enable;
    w_ctrl_word[8 +: PrescaleWidth] = r_prescale;
    w_rdata                        = '0;
    case (w_offset)
      3'd0:    w_rdata = r_mtime[31:0];
      3'd1:    w_rdata = r_mtime[63:32];
      3'd2:    w_rdata = r_mtimecmp[31:0];
      3'd3:    w_rdata = r_mtimecmp[63:32];
      3'd4:    w_rdata = w_ctrl_word;
      default: w_rdata = '0;
    endcase
  end

  // Compute next timer state: counting first, then bus writes override it.
  always_comb begin
    w_mtime_nxt    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    w_enable_nxt   = r_enable;
    w_prescale_nxt = r_prescale;
    w_ctrl_merge   = w_ctrl_word;
    if (!r_enable)   w_divider_nxt = r_divider;
    else if (w_tick) w_divider_nxt = '0;
    else             w_divider_nxt = r_divider + {{(PrescaleWidth-1){1'b0}}, 1'b1};

    if (w_wr) begin
      case (w_offset)
        // Writing either mtime half discards this cycle's tick, and the
        // other half keeps its pre-edge value (no carry across halves).
        3'd0: w_mtime_nxt = {r_mtime[63:32], merge_bytes(r_mtime[31:0], w_wdata, w_be)};
        3'd1: w_mtime_nxt = {merge_bytes(r_mtime[63:32], w_wdata, w_be), r_mtime[31:0]};
        3'd2: w_mtimecmp_nxt = {r_mtimecmp[63:32], merge_bytes(r_mtimecmp[31:0], w_wdata, w_be)};
        3'd3: w_mtimecmp_nxt = {merge_bytes(r_mtimecmp[63:32], w_wdata, w_be), r_mtimecmp[31:0]};
        3'd4: begin
          w_ctrl_merge   = merge_bytes(w_ctrl_word, w_wdata, w_be);
          w_enable_nxt   = w_ctrl_merge[0];
          w_prescale_nxt = w_ctrl_merge[8 +: PrescaleWidth];
          w_divider_nxt  = '0;
        end
        default: w_ctrl_merge = w_ctrl_word;
      endcase
    end else begin
      w_ctrl_merge = w_ctrl_word;
    end
  end

  // Timer, compare and control registers, plus the interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= {64{1'b1}};
      r_enable   <= 1'b1;
      r_prescale <= '0;
      r_divider  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_enable   <= w_enable_nxt;
      r_prescale <= w_prescale_nxt;
      r_divider  <= w_divider_nxt;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  // Read response pipeline: capture on accept, drive during the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_rd;
      if (w_rd) r_resp_data <= w_rdata;
      else      r_resp_data <= r_resp_data;
    end
  end

  assign bus_interface.resp_oe   = r_resp_valid;
  assign bus_interface.resp_data = r_resp_data;
  assign timer_irq               = r_irq;

endmodule

// File: tb/tb_arilla_timer_responder.sv
// Directed bench for arilla_timer_responder. Inputs change on the falling
// edge, and outputs are sampled on the falling edge or just after a reset edge.
module tb_arilla_timer_responder;
  localparam logic [31:0] Base = 32'h0000_0200;

  logic clk = 1'b0;
  logic rst_n;
  logic timer_irq;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  arilla_bus_if bus ();

  arilla_timer_responder #(
    .BaseAddress  (Base),
    .PrescaleWidth(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_interface(bus),
    .timer_irq    (timer_irq)
  );

  // Compare one observed value against its expected value.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.address     = 32'd0;
    bus.byte_enable = 4'd0;
    bus.read        = 1'b0;
    bus.write       = 1'b0;
    bus.init_data   = 32'd0;
    bus.init_oe     = 1'b0;
  endtask

  // Single write cycle. Starts and ends on a falling edge.
  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
    bus.address     = Base + {29'd0, off};
    bus.byte_enable = be;
    bus.write       = 1'b1;
    bus.init_data   = d;
    bus.init_oe     = 1'b1;
    @(negedge clk);
    bus_idle();
  endtask

  // Single read. Returns the response-cycle bus state.
  task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic oe);
    bus.address     = addr;
    bus.byte_enable = 4'hF;
    bus.read        = 1'b1;
    @(negedge clk);
    bus_idle();
    oe = bus.resp_oe;
    d  = bus.data;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        oe;
    rd(Base + {29'd0, off}, d, oe);
    check_val({tag, "_oe"}, {63'd0, oe}, 64'd1);
    check_val(tag, {32'd0, d}, {32'd0, exp});
  endtask

  initial begin
    logic [31:0] v1, v2;
    logic        oe;

    // Reset and idle.
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_oe", {63'd0, bus.resp_oe}, 64'd0);
    check_val("rst_irq", {63'd0, timer_irq}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_oe", {63'd0, bus.resp_oe}, 64'd0);
    end
    rd_chk("idle_mtime", 3'd0, 32'd10);
    @(negedge clk);
    check_val("post_rd_oe", {63'd0, bus.resp_oe}, 64'd0);
    check_val("idle_irq", {63'd0, timer_irq}, 64'd0);

    // Prescale 3: 40 cycles give exactly 10 ticks.
    wr(3'd4, 32'h0000_0301, 4'hF);
    rd(Base, v1, oe);
    repeat (39) @(negedge clk);
    rd(Base, v2, oe);
    check_val("presc_delta", {32'd0, v2 - v1}, 64'd10);
    rd_chk("ctrl_rd", 3'd4, 32'h0000_0301);

    // Disabled: mtime holds.
    wr(3'd4, 32'd0, 4'hF);
    rd(Base, v1, oe);
    repeat (20) @(negedge clk);
    rd(Base, v2, oe);
    check_val("hold", {32'd0, v2}, {32'd0, v1});

    // Compare at 50: irq rises one cycle after mtime reaches 50.
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd2, 32'd50, 4'hF);
    check_val("irq_pre", {63'd0, timer_irq}, 64'd0);
    wr(3'd4, 32'd1, 4'hF);
    repeat (50) @(negedge clk);
    check_val("irq_at50", {63'd0, timer_irq}, 64'd0);
    @(negedge clk);
    check_val("irq_rise", {63'd0, timer_irq}, 64'd1);
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    check_val("irq_lag", {63'd0, timer_irq}, 64'd1);
    @(negedge clk);
    check_val("irq_fall", {63'd0, timer_irq}, 64'd0);

    // Byte-lane write.
    wr(3'd2, 32'h00AB_0000, 4'b0100);
    rd_chk("be_merge", 3'd2, 32'hFFAB_FFFF);

    // Carry into the upper half.
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd4, 32'd1, 4'hF);
    @(negedge clk);
    rd_chk("carry_hi", 3'd1, 32'd1);
    rd_chk("carry_lo", 3'd0, 32'd1);

    // Write colliding with a tick: the written value wins.
    wr(3'd0, 32'h1234_0000, 4'hF);
    rd_chk("coll_full", 3'd0, 32'h1234_0000);
    rd_chk("coll_hi", 3'd1, 32'd1);
    wr(3'd0, 32'h0000_00FF, 4'b0001);
    rd_chk("coll_byte", 3'd0, 32'h1234_00FF);

    // Miss and reserved offsets.
    rd(Base - 32'd1, v1, oe);
    check_val("miss_oe", {63'd0, oe}, 64'd0);
    rd_chk("rsvd6", 3'd6, 32'd0);
    wr(3'd5, 32'hDEAD_BEEF, 4'hF);
    rd_chk("rsvd5", 3'd5, 32'd0);

    // Back-to-back reads of offsets 2, 3, 4.
    bus.byte_enable = 4'hF;
    bus.read        = 1'b1;
    bus.address     = Base + 32'd2;
    @(negedge clk);
    check_val("b2b_oe0", {63'd0, bus.resp_oe}, 64'd1);
    check_val("b2b_d0", {32'd0, bus.data}, {32'd0, 32'hFFAB_FFFF});
    bus.address = Base + 32'd3;
    @(negedge clk);
    check_val("b2b_oe1", {63'd0, bus.resp_oe}, 64'd1);
    check_val("b2b_d1", {32'd0, bus.data}, 64'd0);
    bus.address = Base + 32'd4;
    @(negedge clk);
    check_val("b2b_oe2", {63'd0, bus.resp_oe}, 64'd1);
    check_val("b2b_d2", {32'd0, bus.data}, 64'd1);
    bus_idle();
    @(negedge clk);
    check_val("b2b_end", {63'd0, bus.resp_oe}, 64'd0);

    // Reset during a response cycle releases the bus at once.
    bus.read    = 1'b1;
    bus.address = Base;
    @(negedge clk);
    bus_idle();
    check_val("mid_oe", {63'd0, bus.resp_oe}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rel", {63'd0, bus.resp_oe}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("rst_cmp", 3'd2, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 3'd4, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
